trdb_word_fifo: RTL

Elastic buffer directly downstream of the trace debugger's packet stream aligner. It captures the `packet_word_o`/`packet_word_valid_o` stream, which has no backpressure, into a first-word-fall-through FIFO. It presents the words to the trace sink with a valid/ready handshake. Because the producer cannot stall, words arriving while the FIFO is full are dropped. Every drop is counted and raises a sticky overflow flag, so trace loss is never silent.

---
 rtl/trdb_word_fifo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/trdb_word_fifo.sv
// trdb_word_fifo
// ---------------------------------------------------------------------------
// Elastic first-word-fall-through buffer behind the trace packet stream
// aligner. The producer has no backpressure, so a word arriving while the
// buffer is full (and not being drained in the same cycle) is dropped. Drops
// are counted by a saturating counter and latched into a sticky overflow flag
// so trace loss is always visible to the sink.
//
// Parameters:
//   XLEN  - word width
//   DEPTH - number of entries (power of two, >= 2)
//   CNTW  - width of the saturating drop counter
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset (priority over clear_i)
//   word_i        incoming packet word
//   word_valid_i  word_i valid; no ready, word is taken or dropped
//   clear_i       synchronous flush of contents and statistics
//   word_o        head-of-FIFO word (combinational from storage)
//   word_valid_o  FIFO non-empty
//   word_ready_i  sink accepts word_o this cycle
//   fill_o        current number of entries
//   empty_o       fill == 0
//   full_o        fill == DEPTH
//   overflow_o    sticky: a word was dropped since last reset/clear
//   drop_cnt_o    saturating count of dropped words
// ---------------------------------------------------------------------------
module trdb_word_fifo #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [XLEN-1:0]          word_i,
  input  logic                     word_valid_i,
  input  logic                     clear_i,
  output logic [XLEN-1:0]          word_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [CNTW-1:0]          drop_cnt_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;

  // Elaboration-time sanity checks on the parameters.
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
    $error("trdb_word_fifo: DEPTH must be a power of two >= 2");
  end
  if (CNTW < 1) begin : g_cntw_check
    $error("trdb_word_fifo: CNTW must be >= 1");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
  logic            overflow_q, overflow_d;

  // -------------------------------------------------------------------------
  // Status decode (registered state only)
  // -------------------------------------------------------------------------
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          ptr_wrap_diff;
  logic          full;
  logic          empty;

  assign wr_idx        = wr_ptr_q[AW-1:0];
  assign rd_idx        = rd_ptr_q[AW-1:0];
  assign ptr_wrap_diff = wr_ptr_q[AW] ^ rd_ptr_q[AW];
  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign full          = ptr_wrap_diff && (wr_idx == rd_idx);

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic pop;
  logic push;
  logic drop;
  logic flush;

  assign flush = rst_i || clear_i;
  assign pop   = !empty && word_ready_i;
  // A pop in the same cycle frees the head slot, so a full FIFO can still
  // accept; this is the only path from word_ready_i and it ends in state.
  assign push  = word_valid_i && (!full || pop);
  assign drop  = word_valid_i && full && !pop;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    if (flush) begin
      // Flush voids any concurrent push, pop or drop.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != {CNTW{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + CNTW'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    drop_cnt_q <= drop_cnt_d;
    overflow_q <= overflow_d;
  end

  // -------------------------------------------------------------------------
  // Storage: contents are don't-care while empty, so no reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem_q[wr_idx] <= word_i;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign word_o       = mem_q[rd_idx];
  assign word_valid_o = !empty;
  assign fill_o       = wr_ptr_q - rd_ptr_q;
  assign empty_o      = empty;
  assign full_o       = full;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
